// File: rtl/wb_stage_gen.sv
// Write-back stage: registers a multi-lane MEM bundle, forms register-file writes,
// raises an exception flush and serializes committed writes into a debug-trace FIFO.
module wb_stage_gen #(
    parameter int unsigned LANES       = 2,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_valid,
    output logic                  wb_allowin,
    input  logic [LANES-1:0]      mem_lane_v,
    input  logic [32*LANES-1:0]   mem_pc,
    input  logic [5*LANES-1:0]    mem_wnum,
    input  logic [2*LANES-1:0]    mem_sel,
    input  logic [3*LANES-1:0]    mem_ldcon,
    input  logic [2*LANES-1:0]    mem_adrl,
    input  logic [32*LANES-1:0]   mem_alu_data,
    input  logic [32*LANES-1:0]   mem_rdata,
    input  logic [LANES-1:0]      mem_exc,
    output logic [4*LANES-1:0]    rf_we,
    output logic [5*LANES-1:0]    rf_wnum,
    output logic [32*LANES-1:0]   rf_wdata,
    output logic                  flush,
    output logic [31:0]           flush_pc,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [31:0]           trace_pc,
    output logic [3:0]            trace_wen,
    output logic [4:0]            trace_wnum,
    output logic [31:0]           trace_wdata
);

    localparam int unsigned AW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_t;

    // Byte enables and aligned write data for one lane: {we[3:0], data[31:0]}
    function automatic logic [35:0] lane_result(
        input logic [1:0]  sel,
        input logic [2:0]  ldcon,
        input logic [1:0]  adrl,
        input logic [31:0] alu,
        input logic [31:0] rdata
    );
        logic [31:0] sh;
        logic [35:0] r;
        sh = rdata >> {adrl, 3'b000};
        r  = 36'd0;
        case (sel)
            2'd1: r = {4'hF, alu};
            2'd2: begin
                case (ldcon)
                    3'd0:    r = {4'hF, {{24{sh[7]}}, sh[7:0]}};
                    3'd1:    r = {4'hF, 24'd0, sh[7:0]};
                    3'd2:    r = {4'hF, {{16{sh[15]}}, sh[15:0]}};
                    3'd3:    r = {4'hF, 16'd0, sh[15:0]};
                    default: r = {4'hF, rdata};
                endcase
            end
            2'd3: begin
                if (ldcon == 3'd5) begin
                    r = {4'b1111 << (2'd3 - adrl), rdata << {(2'd3 - adrl), 3'b000}};
                end else begin
                    r = {4'b1111 >> adrl, sh};
                end
            end
            default: r = 36'd0;
        endcase
        return r;
    endfunction

    logic                  valid_q;
    logic [LANES-1:0]      lane_v_q;
    logic [32*LANES-1:0]   pc_q;
    logic [5*LANES-1:0]    wnum_q;
    logic [2*LANES-1:0]    sel_q;
    logic [3*LANES-1:0]    ldcon_q;
    logic [2*LANES-1:0]    adrl_q;
    logic [32*LANES-1:0]   alu_q;
    logic [32*LANES-1:0]   rdata_q;
    logic [LANES-1:0]      exc_q;

    logic [CW-1:0]         count_q;
    logic [AW-1:0]         wptr_q;
    logic [AW-1:0]         rptr_q;
    trace_t                fifo_q [TRACE_DEPTH];

    logic [LANES-1:0][3:0]    we_c;
    logic [LANES-1:0][31:0]   wd_c;
    logic [LANES-1:0]         push_c;
    logic [LANES-1:0][AW-1:0] slot_c;
    logic [CW-1:0]            n_commit_c;
    logic [CW-1:0]            n_push_c;
    logic [CW-1:0]            free_c;
    logic                     exc_seen_c;
    logic [31:0]              flush_pc_c;
    logic [35:0]              res_c;
    logic                     fire_c;
    logic                     pop_c;
    trace_t                   head_c;

    // Per-lane results; lanes from the oldest excepting lane onward are squashed
    always_comb begin
        we_c       = '0;
        wd_c       = '0;
        push_c     = '0;
        slot_c     = '0;
        n_commit_c = '0;
        n_push_c   = '0;
        exc_seen_c = 1'b0;
        flush_pc_c = '0;
        res_c      = '0;
        for (int i = 0; i < LANES; i++) begin
            if (exc_q[i] && !exc_seen_c) begin
                exc_seen_c = 1'b1;
                flush_pc_c = pc_q[32*i +: 32];
            end
            res_c   = lane_result(sel_q[2*i +: 2], ldcon_q[3*i +: 3], adrl_q[2*i +: 2],
                                  alu_q[32*i +: 32], rdata_q[32*i +: 32]);
            wd_c[i] = res_c[31:0];
            if (lane_v_q[i] && !exc_seen_c) begin
                n_commit_c = n_commit_c + CW'(1);
                if (sel_q[2*i +: 2] != 2'd0 && wnum_q[5*i +: 5] != 5'd0) begin
                    we_c[i]   = res_c[35:32];
                    push_c[i] = 1'b1;
                    slot_c[i] = wptr_q + AW'(n_push_c);
                    n_push_c  = n_push_c + CW'(1);
                end
            end
        end
    end

    // Fire only when the trace FIFO can absorb every committing lane
    assign free_c      = CW'(TRACE_DEPTH) - count_q;
    assign fire_c      = valid_q && (free_c >= n_commit_c);
    assign wb_allowin  = !valid_q || fire_c;
    assign trace_valid = (count_q != '0);
    assign pop_c       = trace_valid && trace_ready;

    always_comb begin
        rf_we    = '0;
        rf_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            rf_we[4*i +: 4]     = fire_c ? we_c[i] : 4'd0;
            rf_wdata[32*i +: 32] = wd_c[i];
        end
    end

    assign rf_wnum  = wnum_q;
    assign flush    = fire_c && exc_seen_c;
    assign flush_pc = flush_pc_c;

    assign head_c      = fifo_q[rptr_q];
    assign trace_pc    = head_c.pc;
    assign trace_wen   = head_c.wen;
    assign trace_wnum  = head_c.wnum;
    assign trace_wdata = head_c.wdata;

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            if (wb_allowin) valid_q <= mem_valid;
            if (fire_c) wptr_q <= wptr_q + AW'(n_push_c);
            if (pop_c) rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + (fire_c ? n_push_c : CW'(0)) - (pop_c ? CW'(1) : CW'(0));
        end
    end

    // Bundle payload; qualified by valid_q so no reset needed
    always_ff @(posedge clk) begin
        if (wb_allowin && mem_valid) begin
            lane_v_q <= mem_lane_v;
            pc_q     <= mem_pc;
            wnum_q   <= mem_wnum;
            sel_q    <= mem_sel;
            ldcon_q  <= mem_ldcon;
            adrl_q   <= mem_adrl;
            alu_q    <= mem_alu_data;
            rdata_q  <= mem_rdata;
            exc_q    <= mem_exc;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (fire_c && push_c[i]) begin
                fifo_q[slot_c[i]] <= {pc_q[32*i +: 32], we_c[i], wnum_q[5*i +: 5], wd_c[i]};
            end
        end
    end

endmodule
